// File: rtl/line_beat_streamer.sv
// Captures one cache line and streams it out as BEAT_BYTES-wide beats from a start offset,
// in linear (stop at end of line) or wrap-around (critical-word-first) order.
module line_beat_streamer #(
   parameter int LINE_BYTES = 256,
   parameter int BEAT_BYTES = 1,
   parameter int OFF_W      = $clog2(LINE_BYTES),
   parameter int LEN_W      = OFF_W + 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [LINE_BYTES*8-1:0] req_line,
   input  logic [OFF_W-1:0]        req_offset,
   input  logic [LEN_W-1:0]        req_len,
   input  logic                    req_wrap,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BEAT_BYTES*8-1:0] out_data,
   output logic [OFF_W-1:0]        out_offset,
   output logic                    out_last,
   output logic                    out_trunc,
   output logic                    busy
);

   localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
   localparam int PTR_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BB_W   = $clog2(BEAT_BYTES);
   localparam int BEAT_W = BEAT_BYTES * 8;
   localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(BEATS - 1);
   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(BEATS);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t                  state_reg;
   state_t                  state_next;
   logic [LINE_BYTES*8-1:0] line_reg;
   logic [PTR_W-1:0]        ptr_reg;
   logic [LEN_W-1:0]        rem_reg;
   logic                    wrap_reg;

   logic [BEAT_W-1:0]       beats [BEATS];
   logic [OFF_W-1:0]        req_beat_idx;
   logic [PTR_W-1:0]        start_ptr;
   logic [LEN_W-1:0]        start_rem;
   logic                    at_end;
   logic                    accept;
   logic                    beat_fire;

   // View the captured line as an array of beats so the mux indexes by pointer.
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
         assign beats[gi] = line_reg[gi*BEAT_W +: BEAT_W];
      end
   endgenerate

   assign req_beat_idx = req_offset >> BB_W;
   assign start_ptr    = req_beat_idx[PTR_W-1:0];
   assign start_rem    = (req_len == '0) ? LEN_FULL : req_len;
   assign at_end       = (ptr_reg == PTR_END);
   assign accept       = req_valid && req_ready;
   assign beat_fire    = out_valid && out_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      req_ready  = 1'b0;
      out_valid  = 1'b0;
      out_data   = '0;
      out_offset = '0;
      out_last   = 1'b0;
      out_trunc  = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = STREAM;
            end
         end
         STREAM: begin
            busy       = 1'b1;
            out_valid  = 1'b1;
            out_data   = beats[ptr_reg];
            out_offset = OFF_W'(ptr_reg) << BB_W;
            // Linear streams end at the line boundary even if beats remain.
            out_last   = (rem_reg == LEN_W'(1)) || (!wrap_reg && at_end);
            out_trunc  = !wrap_reg && at_end && (rem_reg > LEN_W'(1));
            if (out_ready && out_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         line_reg <= '0;
         ptr_reg  <= '0;
         rem_reg  <= '0;
         wrap_reg <= 1'b0;
      end else if (accept) begin
         line_reg <= req_line;
         ptr_reg  <= start_ptr;
         rem_reg  <= start_rem;
         wrap_reg <= req_wrap;
      end else if (beat_fire) begin
         ptr_reg  <= at_end ? '0 : ptr_reg + 1'b1;
         rem_reg  <= rem_reg - 1'b1;
      end
   end

endmodule

// File: tb/tb_line_beat_streamer.sv
// Randomised self-checking bench: two instances (1-byte and 4-byte beats) compared
// against a queue-based model of the expected beat sequence.
module tb_line_beat_streamer;
   localparam int LB = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic          a_rst, a_req_valid, a_req_ready, a_req_wrap;
   logic          a_out_valid, a_out_ready, a_out_last, a_out_trunc, a_busy;
   logic [2047:0] a_req_line;
   logic [7:0]    a_req_offset, a_out_offset, a_out_data;
   logic [8:0]    a_req_len;

   logic          b_rst, b_req_valid, b_req_ready, b_req_wrap;
   logic          b_out_valid, b_out_ready, b_out_last, b_out_trunc, b_busy;
   logic [2047:0] b_req_line;
   logic [7:0]    b_req_offset, b_out_offset;
   logic [31:0]   b_out_data;
   logic [8:0]    b_req_len;

   line_beat_streamer #(.LINE_BYTES(LB), .BEAT_BYTES(1)) dut_a (
      .clock(clk), .reset(a_rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_line(a_req_line), .req_offset(a_req_offset), .req_len(a_req_len),
      .req_wrap(a_req_wrap), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_offset(a_out_offset), .out_last(a_out_last),
      .out_trunc(a_out_trunc), .busy(a_busy));

   line_beat_streamer #(.LINE_BYTES(LB), .BEAT_BYTES(4)) dut_b (
      .clock(clk), .reset(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_line(b_req_line), .req_offset(b_req_offset), .req_len(b_req_len),
      .req_wrap(b_req_wrap), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_offset(b_out_offset), .out_last(b_out_last),
      .out_trunc(b_out_trunc), .busy(b_busy));

   // Expected beat sequence for the request in flight.
   int          e_off[$];
   logic [31:0] e_data[$];
   bit          e_last[$];
   bit          e_trunc[$];

   function automatic void build_exp(input int off, input int len, input bit wrap,
                                     input int bb, input logic [2047:0] line);
      int beats = LB / bb;
      int p = off / bb;
      int n = (len == 0) ? beats : len;
      bit tr = 1'b0;
      e_off.delete(); e_data.delete(); e_last.delete(); e_trunc.delete();
      if (!wrap && n > beats - p) begin
         n  = beats - p;
         tr = 1'b1;
      end
      for (int k = 0; k < n; k++) begin
         int idx = (p + k) % beats;
         logic [31:0] d = '0;
         for (int b = 0; b < bb; b++) d[8*b +: 8] = line[(idx*bb + b)*8 +: 8];
         e_off.push_back(idx * bb);
         e_data.push_back(d);
         e_last.push_back(k == n - 1);
         e_trunc.push_back((k == n - 1) && tr);
      end
   endfunction

   function automatic logic [2047:0] ident_line();
      logic [2047:0] l;
      for (int i = 0; i < LB; i++) l[8*i +: 8] = 8'(i);
      return l;
   endfunction

   function automatic logic [2047:0] rand_line();
      logic [2047:0] l;
      for (int i = 0; i < LB / 4; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   task automatic run_a(input string name, input int off, input int len, input bit wrap,
                        input int stall_pct, input int stall_beat, input int stall_cyc,
                        input bit hold_valid, input logic [2047:0] line);
      int beat = 0;
      int cyc = 0;
      int stalled = 0;
      int n;
      bit rdy;
      logic [7:0] ed;
      build_exp(off, len, wrap, 1, line);
      n = e_off.size();
      n_cmp++;
      if (a_req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s idle_ready: got %b want 1", name, a_req_ready);
      end
      a_req_valid = 1'b1; a_req_offset = 8'(off); a_req_len = 9'(len);
      a_req_wrap = wrap; a_req_line = line;
      @(negedge clk);
      if (!hold_valid) a_req_valid = 1'b0;
      while (beat < n && cyc < 5000) begin
         rdy = ($urandom_range(99) >= stall_pct);
         if (beat == stall_beat && stalled < stall_cyc) begin
            rdy = 1'b0;
            stalled++;
         end
         ed = e_data[beat][7:0];
         n_cmp++;
         if ({a_out_valid, a_busy, a_req_ready, a_out_offset, a_out_data, a_out_last, a_out_trunc} !==
             {1'b1, 1'b1, 1'b0, 8'(e_off[beat]), ed, e_last[beat], e_trunc[beat]}) begin
            n_bad++;
            $display("FAIL %s beat%0d: got v=%b busy=%b rr=%b off=%h d=%h last=%b tr=%b want v=1 busy=1 rr=0 off=%h d=%h last=%b tr=%b",
                     name, beat, a_out_valid, a_busy, a_req_ready, a_out_offset, a_out_data,
                     a_out_last, a_out_trunc, 8'(e_off[beat]), ed, e_last[beat], e_trunc[beat]);
         end
         a_out_ready = rdy;
         if (rdy) begin
            if (beat == n - 1) a_req_valid = 1'b0;
            beat++;
         end
         @(negedge clk);
         cyc++;
      end
      a_out_ready = 1'b0;
      a_req_valid = 1'b0;
      if (beat < n) begin
         n_cmp++; n_bad++;
         $display("FAIL %s timeout: got %0d beats want %0d", name, beat, n);
      end
      n_cmp++;
      if ({a_out_valid, a_req_ready, a_busy} !== 3'b010) begin
         n_bad++;
         $display("FAIL %s end_idle: got v=%b rr=%b busy=%b want v=0 rr=1 busy=0",
                  name, a_out_valid, a_req_ready, a_busy);
      end
      if (stall_pct == 0 && stall_cyc == 0) begin
         n_cmp++;
         if (cyc != n) begin
            n_bad++;
            $display("FAIL %s cycles: got %0d want %0d", name, cyc, n);
         end
      end
      $display("txn %s off=%h len=%0d wrap=%b beats=%0d cycles=%0d", name, off, len, wrap, beat, cyc);
   endtask

   task automatic run_b(input string name, input int off, input int len, input bit wrap,
                        input logic [2047:0] line);
      int beat = 0;
      int n;
      build_exp(off, len, wrap, 4, line);
      n = e_off.size();
      b_req_valid = 1'b1; b_req_offset = 8'(off); b_req_len = 9'(len);
      b_req_wrap = wrap; b_req_line = line; b_out_ready = 1'b1;
      @(negedge clk);
      b_req_valid = 1'b0;
      while (beat < n) begin
         n_cmp++;
         if ({b_out_valid, b_out_offset, b_out_data, b_out_last, b_out_trunc} !==
             {1'b1, 8'(e_off[beat]), e_data[beat], e_last[beat], e_trunc[beat]}) begin
            n_bad++;
            $display("FAIL %s beat%0d: got v=%b off=%h d=%h last=%b tr=%b want v=1 off=%h d=%h last=%b tr=%b",
                     name, beat, b_out_valid, b_out_offset, b_out_data, b_out_last, b_out_trunc,
                     8'(e_off[beat]), e_data[beat], e_last[beat], e_trunc[beat]);
         end
         beat++;
         @(negedge clk);
      end
      b_out_ready = 1'b0;
      n_cmp++;
      if ({b_out_valid, b_req_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL %s end_idle: got v=%b rr=%b want v=0 rr=1", name, b_out_valid, b_req_ready);
      end
      $display("txn %s off=%h len=%0d wrap=%b beats=%0d", name, off, len, wrap, beat);
   endtask

   task automatic test_reset();
      a_rst = 1'b0; b_rst = 1'b0;
      a_req_valid = 1'b0; a_out_ready = 1'b0; a_req_line = '0; a_req_offset = '0;
      a_req_len = '0; a_req_wrap = 1'b0;
      b_req_valid = 1'b0; b_out_ready = 1'b0; b_req_line = '0; b_req_offset = '0;
      b_req_len = '0; b_req_wrap = 1'b0;
      #1;
      a_rst = 1'b1; b_rst = 1'b1;
      #1;
      n_cmp++;
      if ({a_req_ready, a_out_valid, a_out_last, a_out_trunc, a_busy, a_out_data, a_out_offset} !== {1'b1, 20'h0}) begin
         n_bad++;
         $display("FAIL reset_a: got rr=%b v=%b last=%b tr=%b busy=%b d=%h off=%h want rr=1 rest 0",
                  a_req_ready, a_out_valid, a_out_last, a_out_trunc, a_busy, a_out_data, a_out_offset);
      end
      n_cmp++;
      if ({b_req_ready, b_out_valid, b_busy, b_out_data} !== {1'b1, 34'h0}) begin
         n_bad++;
         $display("FAIL reset_b: got rr=%b v=%b busy=%b d=%h want rr=1 v=0 busy=0 d=0",
                  b_req_ready, b_out_valid, b_busy, b_out_data);
      end
      repeat (2) @(negedge clk);
      a_rst = 1'b0; b_rst = 1'b0;
      @(negedge clk);
      $display("txn reset done");
   endtask

   task automatic test_linear_basic();
      run_a("linear_basic", 'h10, 4, 1'b0, 0, -1, 0, 1'b0, ident_line());
   endtask

   task automatic test_wrap_boundary();
      run_a("wrap_boundary", 'hFE, 4, 1'b1, 0, -1, 0, 1'b0, ident_line());
   endtask

   task automatic test_linear_trunc();
      run_a("linear_trunc", 'hFE, 4, 1'b0, 0, -1, 0, 1'b0, ident_line());
   endtask

   task automatic test_backpressure();
      run_a("backpressure", 'h20, 6, 1'b0, 0, 2, 3, 1'b0, ident_line());
   endtask

   task automatic test_full_wrap_hold_valid();
      run_a("full_wrap_hold", 'h80, 0, 1'b1, 0, -1, 0, 1'b1, ident_line());
   endtask

   task automatic test_wide_beats();
      run_b("wide_linear", 'h07, 2, 1'b0, ident_line());
      run_b("wide_wrap", 'hF3, 5, 1'b1, rand_line());
      run_b("wide_trunc", 'hF9, 9, 1'b0, rand_line());
      // Abandon a stream with an asynchronous reset between clock edges.
      b_req_valid = 1'b1; b_req_offset = 8'h40; b_req_len = 9'd0; b_req_wrap = 1'b1;
      b_req_line = rand_line(); b_out_ready = 1'b1;
      @(negedge clk);
      b_req_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2 b_rst = 1'b1;
      #1;
      n_cmp++;
      if ({b_out_valid, b_req_ready, b_busy, b_out_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
         n_bad++;
         $display("FAIL wide_midreset: got v=%b rr=%b busy=%b d=%h want v=0 rr=1 busy=0 d=0",
                  b_out_valid, b_req_ready, b_busy, b_out_data);
      end
      @(negedge clk);
      b_rst = 1'b0;
      b_out_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({b_out_valid, b_req_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL wide_after_reset: got v=%b rr=%b want v=0 rr=1", b_out_valid, b_req_ready);
      end
      $display("txn wide_midreset");
      run_b("wide_recover", 'h10, 3, 1'b0, rand_line());
   endtask

   task automatic test_random();
      for (int t = 0; t < 20; t++) begin
         int off = $urandom_range(255);
         int len = ($urandom_range(3) == 0) ? $urandom_range(511) : $urandom_range(12);
         bit wrap = $urandom_range(1);
         run_a($sformatf("rand%0d", t), off, len, wrap, 30, -1, 0, 1'b0, rand_line());
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 6; t++) begin
         run_a($sformatf("b2b%0d", t), $urandom_range(255), $urandom_range(1, 5),
               1'(t % 2), 0, -1, 0, 1'b0, rand_line());
      end
   endtask

   initial begin
      test_reset();
      test_linear_basic();
      test_wrap_boundary();
      test_linear_trunc();
      test_backpressure();
      test_full_wrap_hold_valid();
      test_wide_beats();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
